instruction_cache_sa: RTL and testbench

Parametrised set-associative, read-only instruction cache. It is the next generation of the direct-mapped instruction cache and sits between the fetch stage and main_memory. It generalises sets and ways, adds a ready-handshaked refill, round-robin replacement, a flash invalidate for fence.i, and saturating hit/miss counters. Fetch sees the same out/clk_stall contract as the current cache.

---
 rtl/icache_pkg.sv | 28 ++
 rtl/icache_way_array.sv | 51 +++++
 rtl/instruction_cache_sa.sv | 180 ++++++++++++++++++
 tb/tb_instruction_cache_sa.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
// Shared state type and address-geometry helpers for the set-associative
// instruction cache.
package icache_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      DONE = 2'd2
   } state_e;

   function automatic int off_bits(input int line_w);
      return $clog2(line_w / 8);
   endfunction

   function automatic int idx_bits(input int num_sets);
      return $clog2(num_sets);
   endfunction

   function automatic int tag_bits(input int mem_addr_w, input int num_sets);
      return mem_addr_w - $clog2(num_sets);
   endfunction

   // Right-justified bit field [lsb +: width] of an address.
   function automatic logic [63:0] addr_field(input logic [63:0] a, input int lsb, input int width);
      return (a >> lsb) & ((64'd1 << width) - 64'd1);
   endfunction

endpackage

// File: rtl/icache_way_array.sv
// One cache way: per-set valid/tag/data flops with a set-indexed read port,
// a fill write port and a flash clear of all valid bits.
module icache_way_array
   import icache_pkg::*;
#(
   parameter int LINE_W   = 256,
   parameter int TAG_W    = 6,
   parameter int NUM_SETS = 8,
   parameter int IDX_W    = 3
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              clear_i,
   input  logic [IDX_W-1:0]  rd_idx_i,
   output logic              rd_valid_o,
   output logic [TAG_W-1:0]  rd_tag_o,
   output logic [LINE_W-1:0] rd_data_o,
   input  logic              wr_en_i,
   input  logic [IDX_W-1:0]  wr_idx_i,
   input  logic [TAG_W-1:0]  wr_tag_i,
   input  logic [LINE_W-1:0] wr_data_i,
   input  logic              wr_valid_i
);

   logic [NUM_SETS-1:0] valid_q;
   logic [TAG_W-1:0]    tag_q  [NUM_SETS];
   logic [LINE_W-1:0]   data_q [NUM_SETS];

   // Flash clear takes priority over a same-cycle fill.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         valid_q <= '0;
      end else if (clear_i) begin
         valid_q <= '0;
      end else if (wr_en_i) begin
         valid_q[wr_idx_i] <= wr_valid_i;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en_i) begin
         tag_q[wr_idx_i]  <= wr_tag_i;
         data_q[wr_idx_i] <= wr_data_i;
      end
   end

   assign rd_valid_o = valid_q[rd_idx_i];
   assign rd_tag_o   = tag_q[rd_idx_i];
   assign rd_data_o  = data_q[rd_idx_i];

endmodule

// File: rtl/instruction_cache_sa.sv
// Set-associative read-only instruction cache: tag compare, hit select, word
// mux, refill FSM, round-robin victim pointers and saturating counters.
module instruction_cache_sa
   import icache_pkg::*;
#(
   parameter int ADDR_W     = 32,
   parameter int LINE_W     = 256,
   parameter int MEM_ADDR_W = 9,
   parameter int NUM_SETS   = 8,
   parameter int NUM_WAYS   = 2,
   parameter int CNT_W      = 32
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [ADDR_W-1:0]     addr,
   output logic [31:0]           out,
   output logic                  clk_stall,
   input  logic                  invalidate,
   output logic [MEM_ADDR_W-1:0] mem_block_addr,
   output logic                  readmem,
   input  logic [LINE_W-1:0]     new_line,
   input  logic                  mem_ready,
   output logic [CNT_W-1:0]      hit_count,
   output logic [CNT_W-1:0]      miss_count
);

   localparam int OFF    = off_bits(LINE_W);
   localparam int IDX    = idx_bits(NUM_SETS);
   localparam int TAG    = tag_bits(MEM_ADDR_W, NUM_SETS);
   localparam int WORD_W = OFF - 2;
   localparam int VP_W   = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;

   state_e                state_q, state_d;
   logic [MEM_ADDR_W-1:0] blk_q, blk_d;
   logic                  readmem_q, readmem_d;
   logic                  inval_seen_q, inval_seen_d;
   logic [VP_W-1:0]       victim_q [NUM_SETS];
   logic [CNT_W-1:0]      hit_cnt_q, miss_cnt_q;

   logic [IDX-1:0]        idx_s, fill_idx_s;
   logic [TAG-1:0]        tag_s, fill_tag_s;
   logic [WORD_W-1:0]     word_s;
   logic [VP_W-1:0]       fill_way_s;
   logic [NUM_WAYS-1:0]   way_valid_s;
   logic [TAG-1:0]        way_tag_s  [NUM_WAYS];
   logic [LINE_W-1:0]     way_data_s [NUM_WAYS];
   logic [NUM_WAYS-1:0]   way_match_s;
   logic                  hit_s;
   logic [LINE_W-1:0]     hit_line_s;
   logic [31:0]           hit_word_s;
   logic                  fill_we_s, fill_valid_s, hit_inc_s, miss_inc_s;

   assign word_s = WORD_W'(addr_field(64'(addr), 2, WORD_W));
   assign idx_s  = IDX'(addr_field(64'(addr), OFF, IDX));
   assign tag_s  = TAG'(addr_field(64'(addr), OFF + IDX, TAG));

   // Fills always target the latched block, never the live fetch address.
   assign fill_idx_s   = blk_q[IDX-1:0];
   assign fill_tag_s   = blk_q[MEM_ADDR_W-1:IDX];
   assign fill_way_s   = victim_q[fill_idx_s];
   assign fill_valid_s = ~(invalidate | inval_seen_q);

   for (genvar w = 0; w < NUM_WAYS; w++) begin : g_way
      icache_way_array #(
         .LINE_W   (LINE_W),
         .TAG_W    (TAG),
         .NUM_SETS (NUM_SETS),
         .IDX_W    (IDX)
      ) u_way (
         .clk        (clk),
         .reset_n    (reset_n),
         .clear_i    (invalidate),
         .rd_idx_i   (idx_s),
         .rd_valid_o (way_valid_s[w]),
         .rd_tag_o   (way_tag_s[w]),
         .rd_data_o  (way_data_s[w]),
         .wr_en_i    (fill_we_s && (fill_way_s == VP_W'(w))),
         .wr_idx_i   (fill_idx_s),
         .wr_tag_i   (fill_tag_s),
         .wr_data_i  (new_line),
         .wr_valid_i (fill_valid_s)
      );
   end

   // Tag compare and one-hot select of the hitting way's line.
   always_comb begin
      way_match_s = '0;
      hit_line_s  = '0;
      for (int w = 0; w < NUM_WAYS; w++) begin
         way_match_s[w] = way_valid_s[w] & (way_tag_s[w] == tag_s);
         hit_line_s     = hit_line_s | ({LINE_W{way_match_s[w]}} & way_data_s[w]);
      end
   end

   assign hit_s      = |way_match_s;
   assign hit_word_s = hit_line_s[{word_s, 5'd0} +: 32];

   // Refill FSM next-state and per-cycle strobes.
   always_comb begin
      state_d      = state_q;
      blk_d        = blk_q;
      readmem_d    = readmem_q;
      fill_we_s    = 1'b0;
      hit_inc_s    = 1'b0;
      miss_inc_s   = 1'b0;
      inval_seen_d = (state_q == FILL) & (inval_seen_q | invalidate);
      case (state_q)
         IDLE: begin
            if (hit_s) begin
               hit_inc_s = 1'b1;
            end else begin
               miss_inc_s = 1'b1;
               blk_d      = {tag_s, idx_s};
               readmem_d  = 1'b1;
               state_d    = FILL;
            end
         end
         FILL: begin
            if (mem_ready) begin
               fill_we_s = 1'b1;
               readmem_d = 1'b0;
               state_d   = DONE;
            end else begin
               state_d = FILL;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // FSM state and refill request registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         blk_q        <= '0;
         readmem_q    <= 1'b0;
         inval_seen_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         blk_q        <= blk_d;
         readmem_q    <= readmem_d;
         inval_seen_q <= inval_seen_d;
      end
   end

   // Round-robin victim pointer advances on every install; held at 0 when direct-mapped.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int s = 0; s < NUM_SETS; s++) begin
            victim_q[s] <= '0;
         end
      end else if (fill_we_s) begin
         victim_q[fill_idx_s] <= (NUM_WAYS > 1) ? fill_way_s + VP_W'(1) : VP_W'(0);
      end
   end

   // Saturating hit/miss counters.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
      end else begin
         if (hit_inc_s && (hit_cnt_q != {CNT_W{1'b1}})) begin
            hit_cnt_q <= hit_cnt_q + CNT_W'(1);
         end
         if (miss_inc_s && (miss_cnt_q != {CNT_W{1'b1}})) begin
            miss_cnt_q <= miss_cnt_q + CNT_W'(1);
         end
      end
   end

   assign clk_stall      = (state_q != IDLE) | ~hit_s;
   assign out            = ((state_q == IDLE) && hit_s) ? hit_word_s : 32'd0;
   assign mem_block_addr = blk_q;
   assign readmem        = readmem_q;
   assign hit_count      = hit_cnt_q;
   assign miss_count     = miss_cnt_q;

endmodule

// File: tb/tb_instruction_cache_sa.sv
// Self-checking bench for instruction_cache_sa: directed scenarios plus random
// fetches against a set/way/round-robin reference model.
module tb_instruction_cache_sa;

   logic         clk = 1'b0;
   logic         reset_n;
   logic [31:0]  addr;
   logic [31:0]  out;
   logic         clk_stall;
   logic         invalidate;
   logic [8:0]   mem_block_addr;
   logic         readmem;
   logic [255:0] new_line = '0;
   logic         mem_ready = 1'b0;
   logic [31:0]  hit_count;
   logic [31:0]  miss_count;

   int checks   = 0;
   int failures = 0;

   bit         m_valid [8][2];
   int         m_tag   [8][2];
   int         m_vic   [8];
   int         m_hits;
   int         m_misses;
   int         lat_cnt = 0;
   logic [8:0] last_blk;

   instruction_cache_sa dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .addr           (addr),
      .out            (out),
      .clk_stall      (clk_stall),
      .invalidate     (invalidate),
      .mem_block_addr (mem_block_addr),
      .readmem        (readmem),
      .new_line       (new_line),
      .mem_ready      (mem_ready),
      .hit_count      (hit_count),
      .miss_count     (miss_count)
   );

   always #5 clk = ~clk;

   function automatic logic [255:0] make_line(input logic [8:0] blk);
      logic [255:0] l;
      for (int k = 0; k < 8; k++) begin
         l[32*k +: 32] = {23'd0, blk} + 32'(k);
      end
      return l;
   endfunction

   // Memory: mem_ready on the third cycle readmem is seen high.
   always @(negedge clk) begin
      if (readmem) begin
         lat_cnt   = lat_cnt + 1;
         mem_ready = (lat_cnt == 3);
         new_line  = make_line(mem_block_addr);
      end else begin
         lat_cnt   = 0;
         mem_ready = 1'b0;
      end
   end

   function automatic logic [31:0] exp_word(input logic [31:0] a);
      return 32'(a[13:5]) + 32'(a[4:2]);
   endfunction

   task automatic model_reset();
      for (int s = 0; s < 8; s++) begin
         m_vic[s] = 0;
         for (int w = 0; w < 2; w++) begin
            m_valid[s][w] = 1'b0;
            m_tag[s][w]   = 0;
         end
      end
      m_hits   = 0;
      m_misses = 0;
   endtask

   task automatic model_invalidate();
      for (int s = 0; s < 8; s++) begin
         for (int w = 0; w < 2; w++) begin
            m_valid[s][w] = 1'b0;
         end
      end
   endtask

   task automatic model_access(input logic [31:0] a, input bit keep_valid, output bit hit);
      int blk, set, tg, way;
      blk = int'(a[13:5]);
      set = blk % 8;
      tg  = blk / 8;
      hit = 1'b0;
      for (int w = 0; w < 2; w++) begin
         if (m_valid[set][w] && m_tag[set][w] == tg) hit = 1'b1;
      end
      if (!hit) begin
         way                = m_vic[set];
         m_valid[set][way]  = keep_valid;
         m_tag[set][way]    = tg;
         m_vic[set]         = (m_vic[set] + 1) % 2;
         m_misses           = m_misses + 1;
      end
   endtask

   task automatic do_reset();
      reset_n    = 1'b0;
      invalidate = 1'b0;
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      model_reset();
   endtask

   // Waits (bounded) for the current addr to be served, then checks it.
   task automatic wait_hit(input string name, input int exp_stalls, input logic [31:0] exp_out);
      int n;
      bit ok;
      n  = 0;
      ok = 1'b0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (readmem) last_blk = mem_block_addr;
         if (!clk_stall) begin
            ok = 1'b1;
            break;
         end
         n++;
      end
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL %s: no hit within 60 cycles, got stalls %0d want %0d", name, n, exp_stalls);
      end
      checks++;
      if (n !== exp_stalls) begin
         failures++;
         $display("FAIL %s stalls: got %0d want %0d", name, n, exp_stalls);
      end
      checks++;
      if (out !== exp_out) begin
         failures++;
         $display("FAIL %s out: got 0x%08h want 0x%08h", name, out, exp_out);
      end
      checks++;
      if (hit_count !== 32'(m_hits) || miss_count !== 32'(m_misses)) begin
         failures++;
         $display("FAIL %s counters: got hit=%0d miss=%0d want hit=%0d miss=%0d", name, hit_count, miss_count, m_hits, m_misses);
      end
      @(posedge clk);
      #1;
      m_hits = m_hits + 1;
   endtask

   task automatic fetch(input string name, input logic [31:0] a);
      bit hit;
      model_access(a, 1'b1, hit);
      addr = a;
      wait_hit(name, hit ? 0 : 5, exp_word(a));
   endtask

   task automatic test_reset();
      reset_n    = 1'b0;
      addr       = 32'd0;
      invalidate = 1'b0;
      @(negedge clk);
      checks++;
      if (out !== 32'd0 || readmem !== 1'b0 || mem_block_addr !== 9'd0 || hit_count !== 32'd0 || miss_count !== 32'd0) begin
         failures++;
         $display("FAIL reset: got out=%0h readmem=%b blk=%0d hit=%0d miss=%0d want all zero", out, readmem, mem_block_addr, hit_count, miss_count);
      end
   endtask

   task automatic test_cold_miss();
      bit hit;
      do_reset();
      model_access(32'h004, 1'b1, hit);
      addr = 32'h004;
      @(negedge clk);
      checks++;
      if (clk_stall !== 1'b1 || readmem !== 1'b0) begin
         failures++;
         $display("FAIL cold_lookup: got stall=%b readmem=%b want 1 0", clk_stall, readmem);
      end
      @(posedge clk);
      #1;
      checks++;
      if (readmem !== 1'b1 || mem_block_addr !== 9'd0 || miss_count !== 32'd1) begin
         failures++;
         $display("FAIL cold_request: got readmem=%b blk=%0d miss=%0d want 1 0 1", readmem, mem_block_addr, miss_count);
      end
      wait_hit("cold_fill", 4, 32'h1);
      @(negedge clk);
      checks++;
      if (hit_count !== 32'd1) begin
         failures++;
         $display("FAIL cold_hit_count: got %0d want 1", hit_count);
      end
   endtask

   task automatic test_same_line();
      do_reset();
      fetch("line_fill", 32'h000);
      fetch("line_w2", 32'h008);
      fetch("line_w7", 32'h01C);
   endtask

   task automatic test_replacement();
      do_reset();
      fetch("rr_a", 32'h000);
      fetch("rr_b", 32'h100);
      fetch("rr_a_hit", 32'h000);
      fetch("rr_b_hit", 32'h100);
      fetch("rr_c_evict_a", 32'h200);
      fetch("rr_b_still", 32'h100);
      fetch("rr_a_refetch", 32'h000);
      @(negedge clk);
      checks++;
      if (miss_count !== 32'd4) begin
         failures++;
         $display("FAIL rr_miss_count: got %0d want 4", miss_count);
      end
      @(posedge clk);
      #1;
      m_hits = m_hits + 1;
      fetch("rr_b_evicted", 32'h100);
   endtask

   task automatic test_invalidate_fill();
      bit hit;
      do_reset();
      fetch("inv_prefill", 32'h000);
      model_access(32'h040, 1'b0, hit);
      addr = 32'h040;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      invalidate = 1'b1;
      @(posedge clk);
      #1;
      invalidate = 1'b0;
      model_invalidate();
      model_access(32'h040, 1'b1, hit);
      wait_hit("inv_refill", 7, 32'h2);
      fetch("inv_old_line", 32'h000);
   endtask

   task automatic test_addr_change();
      bit hit;
      do_reset();
      model_access(32'h020, 1'b1, hit);
      addr = 32'h020;
      @(posedge clk);
      #1;
      addr = 32'h060;
      model_access(32'h060, 1'b1, hit);
      wait_hit("chg_second", 9, 32'h3);
      checks++;
      if (last_blk !== 9'd3) begin
         failures++;
         $display("FAIL chg_block: got %0d want 3", last_blk);
      end
      fetch("chg_first_hits", 32'h020);
   endtask

   task automatic test_reset_mid_fill();
      do_reset();
      fetch("rst_warm", 32'h020);
      addr = 32'h000;
      @(posedge clk);
      #1;
      @(posedge clk);
      #2;
      reset_n = 1'b0;
      #1;
      checks++;
      if (readmem !== 1'b0 || hit_count !== 32'd0 || miss_count !== 32'd0) begin
         failures++;
         $display("FAIL rst_async: got readmem=%b hit=%0d miss=%0d want 0 0 0", readmem, hit_count, miss_count);
      end
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      model_reset();
      fetch("rst_after", 32'h000);
      fetch("rst_warm_gone", 32'h020);
   endtask

   task automatic test_random();
      logic [31:0] a;
      do_reset();
      for (int i = 0; i < 60; i++) begin
         a = {18'd0, 9'($urandom_range(0, 31)), 3'($urandom_range(0, 7)), 2'b00};
         fetch("rand", a);
         if ($urandom_range(0, 5) == 0) begin
            invalidate = 1'b1;
            @(negedge clk);
            checks++;
            if (clk_stall !== 1'b0) begin
               failures++;
               $display("FAIL rand_inv_lookup: got stall %b want 0", clk_stall);
            end
            @(posedge clk);
            #1;
            invalidate = 1'b0;
            m_hits = m_hits + 1;
            model_invalidate();
         end
      end
   endtask

   initial begin
      reset_n    = 1'b0;
      addr       = 32'd0;
      invalidate = 1'b0;
      last_blk   = 9'd0;
      model_reset();
      test_reset();
      test_cold_miss();
      test_same_line();
      test_replacement();
      test_invalidate_fill();
      test_addr_change();
      test_reset_mid_fill();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
